rom_read_arbiter: RTL and testbench

Shares the single combinational program ROM (32 words, byte-wide read data) between two requesters, e.g. instruction fetch (port 0) and a data/table loader (port 1). Each requester uses a valid/ready request channel and a valid/ready response channel. The block registers the ROM address, captures the ROM data one cycle later, and holds the response until it is taken. Round-robin arbitration prevents starvation. Addresses beyond the ROM depth return zero with an error flag.

---
 rtl/rom_read_arbiter.sv | 72 +++++++
 tb/tb_rom_read_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin shares one combinational ROM between two valid/ready read ports
// ports: clk/rst (async, active-high); rN_req_* request channel and rN_resp_* response channel per port;
//        rom_addr/rom_data registered address out, combinational data in; busy high outside IDLE
module rom_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  input  logic [ADDR_W-1:0] r0_req_addr,
  output logic              r0_req_ready,
  output logic              r0_resp_valid,
  output logic [DATA_W-1:0] r0_resp_data,
  output logic              r0_resp_err,
  input  logic              r0_resp_ready,
  input  logic              r1_req_valid,
  input  logic [ADDR_W-1:0] r1_req_addr,
  output logic              r1_req_ready,
  output logic              r1_resp_valid,
  output logic [DATA_W-1:0] r1_resp_data,
  output logic              r1_resp_err,
  input  logic              r1_resp_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  state_t state, state_nx;
  logic owner, last_owner, err_q, g0, g1, done, in_range;
  logic [DATA_W-1:0] data_q;
  always_comb begin
    g0 = state == IDLE && r0_req_valid && (!r1_req_valid || last_owner);
    g1 = state == IDLE && r1_req_valid && (!r0_req_valid || !last_owner);
    done = state == RESP && (owner ? r1_resp_ready : r0_resp_ready);
    in_range = rom_addr < ADDR_W'(DEPTH);
    state_nx = state == IDLE ? ((g0 || g1) ? FETCH : IDLE) :
               state == FETCH ? RESP : (done ? IDLE : RESP);
  end
  assign r0_req_ready  = g0;
  assign r1_req_ready  = g1;
  assign r0_resp_valid = state == RESP && !owner;
  assign r1_resp_valid = state == RESP && owner;
  assign r0_resp_data  = data_q;
  assign r1_resp_data  = data_q;
  assign r0_resp_err   = err_q;
  assign r1_resp_err   = err_q;
  assign busy          = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // last_owner starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner <= 1'b0;
      last_owner <= 1'b1;
      rom_addr <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (g0 || g1) begin
        owner <= g1;
        rom_addr <= g1 ? r1_req_addr : r0_req_addr;
      end
      if (state == FETCH) begin
        data_q <= in_range ? rom_data : '0;
        err_q <= !in_range;
      end
      if (done) last_owner <= owner;
    end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: randomized + directed bench against a transaction-timing reference model
module tb_rom_read_arbiter;
  logic clk = 0, rst = 1;
  logic v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [31:0] a0 = 0, a1 = 0;
  logic rdy0, rdy1, rv0, rv1, err0, err1, busy;
  logic [7:0] d0, d1, rom_data;
  logic [31:0] rom_addr;
  logic [7:0] rom [32];
  int errors = 0, checks = 0;
  int cyc = 0;
  int rr0_p = 100, rr1_p = 100;
  logic [31:0] q0[$], q1[$];
  logic m_fl, m_own, m_last;
  logic [31:0] m_addr;
  int m_acc;
  logic hs0, hs1;
  always #5 clk = ~clk;
  assign rom_data = rom_addr < 32 ? rom[rom_addr[4:0]] : 8'hEE;
  rom_read_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(v0), .r0_req_addr(a0), .r0_req_ready(rdy0),
    .r0_resp_valid(rv0), .r0_resp_data(d0), .r0_resp_err(err0), .r0_resp_ready(rr0),
    .r1_req_valid(v1), .r1_req_addr(a1), .r1_req_ready(rdy1),
    .r1_resp_valid(rv1), .r1_resp_data(d1), .r1_resp_err(err1), .r1_resp_ready(rr1),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    m_fl = 0; m_own = 0; m_last = 1; m_addr = 0; m_acc = 0; cyc = 0;
  endtask
  task automatic check_reset_outputs();
    check("rst_rdy0", rdy0, 0); check("rst_rdy1", rdy1, 0);
    check("rst_rv0", rv0, 0); check("rst_rv1", rv1, 0);
    check("rst_d0", d0, 0); check("rst_d1", d1, 0);
    check("rst_err0", err0, 0); check("rst_err1", err1, 0);
    check("rst_rom_addr", rom_addr, 0); check("rst_busy", busy, 0);
  endtask
  // one clock cycle: present requests, check outputs against the model mid-cycle, advance model
  task automatic step();
    logic e_g0, e_g1, e_rv, done;
    logic [31:0] e_data;
    if (!v0 && q0.size() > 0) begin v0 = 1; a0 = q0.pop_front(); end
    if (!v1 && q1.size() > 0) begin v1 = 1; a1 = q1.pop_front(); end
    rr0 = $urandom_range(99) < rr0_p;
    rr1 = $urandom_range(99) < rr1_p;
    @(negedge clk);
    e_g0 = !m_fl && v0 && (!v1 || m_last);
    e_g1 = !m_fl && v1 && (!v0 || !m_last);
    e_rv = m_fl && cyc >= m_acc + 2;
    check("req_ready0", rdy0, e_g0);
    check("req_ready1", rdy1, e_g1);
    check("resp_valid0", rv0, e_rv && !m_own);
    check("resp_valid1", rv1, e_rv && m_own);
    check("busy", busy, m_fl);
    check("rom_addr", rom_addr, m_addr);
    if (e_rv) begin
      e_data = m_addr < 32 ? {24'd0, rom[m_addr[4:0]]} : 0;
      check("resp_data", m_own ? d1 : d0, e_data);
      check("resp_err", m_own ? err1 : err0, m_addr >= 32);
    end
    done = e_rv && (m_own ? rr1 : rr0);
    if (done) begin m_fl = 0; m_last = m_own; end
    if (e_g0 || e_g1) begin
      m_fl = 1; m_own = e_g1; m_addr = e_g1 ? a1 : a0; m_acc = cyc;
    end
    hs0 = e_g0; hs1 = e_g1;
    @(posedge clk); #1;
    if (hs0) v0 = 0;
    if (hs1) v1 = 0;
    cyc++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(9))
      7: return 32 + $urandom_range(15);
      8: return $urandom | 32'h8000_0000;
      9: return $urandom_range(1) ? 32'd31 : 32'd32;
      default: return $urandom_range(31);
    endcase
  endfunction
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    rom[1] = 8'h11; rom[2] = 8'h22; rom[5] = 8'hA5;
    #12;
    check_reset_outputs();
    model_reset();
    @(posedge clk); #1 rst = 0;
    // single read of word 5
    q0.push_back(5);
    run(6);
    // simultaneous requests: port 0 first, then alternation
    rst = 1; #1 model_reset(); @(posedge clk); #1;
    q0.push_back(1); q1.push_back(2);
    q0.push_back(1); q1.push_back(2);
    rst = 0;
    run(16);
    // out of range then boundary word
    q1.push_back(40); q1.push_back(31); q1.push_back(32'h1_0000);
    run(12);
    // backpressure on port 0 while port 1 waits
    rr0_p = 0;
    q0.push_back(7); q1.push_back(9);
    run(7);
    rr0_p = 100;
    run(6);
    // only port 1, three back-to-back
    q1.push_back(3); q1.push_back(4); q1.push_back(5);
    run(12);
    // async reset during RESP
    rr0_p = 0;
    q0.push_back(6);
    for (int i = 0; i < 10 && !(m_fl && cyc >= m_acc + 2); i++) step();
    check("reached_resp", m_fl && cyc >= m_acc + 2, 1);
    #2 rst = 1;
    #1 check_reset_outputs();
    v0 = 0; v1 = 0; q0.delete(); q1.delete();
    model_reset();
    @(posedge clk); #1 rst = 0;
    rr0_p = 100;
    run(4);
    // randomized traffic
    rr0_p = 70; rr1_p = 60;
    for (int i = 0; i < 800; i++) begin
      if (q0.size() < 3 && $urandom_range(99) < 35) q0.push_back(rand_addr());
      if (q1.size() < 3 && $urandom_range(99) < 35) q1.push_back(rand_addr());
      if (i % 200 == 199) begin rr0_p = $urandom_range(100); rr1_p = $urandom_range(100); end
      step();
    end
    rr0_p = 100; rr1_p = 100;
    run(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
